// File: rtl/lb_reg_bank.sv
// Local-bus register bank behind the UDP memory gateway: eight R/W registers,
// read-only status/counter words, pulse and sticky registers, fixed-latency reads.
module lb_reg_bank #(
  parameter int unsigned read_pipe_len = 3,
  parameter logic [31:0] id_value      = 32'h4C425247
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [23:0]   addr,
  input  logic          control_strobe,
  input  logic          control_rd,
  input  logic [31:0]   data_out,
  output logic [31:0]   data_in,
  output logic [255:0]  rw_regs,
  output logic [31:0]   pulse_out,
  input  logic [31:0]   status_in,
  output logic [31:0]   sticky_out
);

  localparam int unsigned data_w   = 32;
  localparam int unsigned num_regs = 8;
  // The last pipeline register is data_in itself, so read_pipe_len-1 stages precede it.
  localparam int unsigned stages   = read_pipe_len - 1;
  localparam logic [31:0] unmapped = 32'hDEADF00D;

  logic                 hit;
  logic                 wr_stb;
  logic                 rd_stb;
  logic [data_w-1:0]    rd_mux;
  logic [data_w-1:0]    sticky_clr;
  logic [data_w-1:0]    rw_q [num_regs];
  logic [data_w-1:0]    cycle_cnt;
  logic [data_w-1:0]    wr_cnt;
  logic [data_w-1:0]    pipe_d [stages];
  logic [stages-1:0]    pipe_v;

  assign hit    = (addr[23:8] == 16'h0000);
  assign wr_stb = control_strobe & ~control_rd;
  assign rd_stb = control_strobe & control_rd;

  // Read data selection, sampled in the strobe cycle.
  always_comb begin
    rd_mux = unmapped;
    if (hit) begin
      case (addr[7:0])
        8'h00, 8'h01, 8'h02, 8'h03,
        8'h04, 8'h05, 8'h06, 8'h07: rd_mux = rw_q[addr[2:0]];
        8'h10:                      rd_mux = id_value;
        8'h11:                      rd_mux = cycle_cnt;
        8'h12:                      rd_mux = wr_cnt;
        8'h13:                      rd_mux = status_in;
        8'h14:                      rd_mux = '0;
        8'h15:                      rd_mux = sticky_out;
        default:                    rd_mux = unmapped;
      endcase
    end
  end

  always_comb begin
    sticky_clr = '0;
    if (wr_stb && hit && (addr[7:0] == 8'h15)) sticky_clr = data_out;
  end

  // Register file, counters, pulse and sticky state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(num_regs); i++) rw_q[i] <= '0;
      cycle_cnt  <= '0;
      wr_cnt     <= '0;
      pulse_out  <= '0;
      sticky_out <= '0;
    end else begin
      cycle_cnt  <= cycle_cnt + 32'd1;
      if (wr_stb) wr_cnt <= wr_cnt + 32'd1;
      if (wr_stb && hit && (addr[7:3] == 5'd0)) rw_q[addr[2:0]] <= data_out;
      pulse_out  <= (wr_stb && hit && (addr[7:0] == 8'h14)) ? data_out : '0;
      sticky_out <= (sticky_out & ~sticky_clr) | status_in;
    end
  end

  // Fixed-latency read pipeline; data_in holds the last completed read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(stages); i++) pipe_d[i] <= '0;
      pipe_v  <= '0;
      data_in <= '0;
    end else begin
      pipe_d[0] <= rd_mux;
      pipe_v[0] <= rd_stb;
      for (int i = 1; i < int'(stages); i++) begin
        pipe_d[i] <= pipe_d[i-1];
        pipe_v[i] <= pipe_v[i-1];
      end
      if (pipe_v[stages-1]) data_in <= pipe_d[stages-1];
    end
  end

  for (genvar k = 0; k < int'(num_regs); k++) begin : g_flat
    assign rw_regs[k*data_w +: data_w] = rw_q[k];
  end

endmodule

// File: tb/tb_lb_reg_bank.sv
// Directed bench for lb_reg_bank: vector table of bus transactions plus
// hand-written pipelining, pulse, sticky, reset and counter-wrap sequences.
module tb_lb_reg_bank;

  localparam int unsigned PIPE = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [23:0]  addr;
  logic         control_strobe;
  logic         control_rd;
  logic [31:0]  data_out;
  logic [31:0]  data_in;
  logic [255:0] rw_regs;
  logic [31:0]  pulse_out;
  logic [31:0]  status_in;
  logic [31:0]  sticky_out;

  int total = 0;
  int bad   = 0;
  logic [31:0] tb_cyc;

  lb_reg_bank #(.read_pipe_len(PIPE), .id_value(32'h4C425247)) dut (
    .clk(clk), .rst(rst), .addr(addr), .control_strobe(control_strobe),
    .control_rd(control_rd), .data_out(data_out), .data_in(data_in),
    .rw_regs(rw_regs), .pulse_out(pulse_out), .status_in(status_in),
    .sticky_out(sticky_out)
  );

  always #5 clk = ~clk;

  // Reference cycle count, independent of the DUT.
  always @(posedge clk) begin
    if (rst) tb_cyc <= 32'd0;
    else     tb_cyc <= tb_cyc + 32'd1;
  end

  typedef struct {
    logic        wr;
    logic [23:0] a;
    logic [31:0] d;
    logic [31:0] st;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All bus tasks start and end at a falling edge.
  task automatic bus_wr(input logic [23:0] a, input logic [31:0] d, input logic [31:0] st);
    addr = a; data_out = d; control_rd = 1'b0; control_strobe = 1'b1; status_in = st;
    @(negedge clk);
    control_strobe = 1'b0; status_in = 32'h0;
  endtask

  task automatic bus_rd(input logic [23:0] a, input logic [31:0] st, output logic [31:0] q);
    addr = a; control_rd = 1'b1; control_strobe = 1'b1; status_in = st;
    @(negedge clk);
    control_strobe = 1'b0; control_rd = 1'b0; status_in = 32'h0;
    repeat (PIPE - 1) @(negedge clk);
    q = data_in;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q;
    logic [31:0] exp4 [4];
    logic [23:0] adr4 [4];

    rst = 1'b1; addr = '0; control_strobe = 1'b0; control_rd = 1'b0;
    data_out = '0; status_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_data_in", data_in, 32'h0);
    check("rst_pulse", pulse_out, 32'h0);
    check("rst_sticky", sticky_out, 32'h0);
    check("rst_rw0", rw_regs[31:0], 32'h0);
    check("rst_rw7", rw_regs[255:224], 32'h0);

    // wr, addr, data, status, expected read
    vecs.push_back('{1'b1, 24'h000003, 32'h12345678, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 24'h000003, 32'h0, 32'h0, 32'h12345678});
    vecs.push_back('{1'b1, 24'h000000, 32'hAAAA5555, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 24'h000000, 32'h0, 32'h0, 32'hAAAA5555});
    vecs.push_back('{1'b1, 24'h000007, 32'hFFFFFFFF, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 24'h000007, 32'h0, 32'h0, 32'hFFFFFFFF});
    vecs.push_back('{1'b0, 24'h000010, 32'h0, 32'h0, 32'h4C425247});
    vecs.push_back('{1'b0, 24'h000100, 32'h0, 32'h0, 32'hDEADF00D});
    vecs.push_back('{1'b1, 24'h000105, 32'h11111111, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 24'h000005, 32'h0, 32'h0, 32'h00000000});
    vecs.push_back('{1'b0, 24'h000016, 32'h0, 32'h0, 32'hDEADF00D});
    vecs.push_back('{1'b0, 24'h00000F, 32'h0, 32'h0, 32'hDEADF00D});
    vecs.push_back('{1'b0, 24'h000014, 32'h0, 32'h0, 32'h00000000});
    vecs.push_back('{1'b1, 24'h000010, 32'h00000000, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 24'h000010, 32'h0, 32'h0, 32'h4C425247});
    vecs.push_back('{1'b0, 24'h000012, 32'h0, 32'h0, 32'h00000005});
    vecs.push_back('{1'b0, 24'h000013, 32'h0, 32'h00C0FFEE, 32'h00C0FFEE});
    vecs.push_back('{1'b0, 24'h000015, 32'h0, 32'h0, 32'h00C0FFEE});
    vecs.push_back('{1'b1, 24'h000015, 32'h00C0FFEE, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 24'h000015, 32'h0, 32'h0, 32'h00000000});
    vecs.push_back('{1'b0, 24'h800003, 32'h0, 32'h0, 32'hDEADF00D});
    vecs.push_back('{1'b0, 24'h000012, 32'h0, 32'h0, 32'h00000006});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) bus_wr(vecs[i].a, vecs[i].d, vecs[i].st);
      else begin
        bus_rd(vecs[i].a, vecs[i].st, q);
        check($sformatf("vec%0d_rd_%h", i, vecs[i].a), q, vecs[i].exp);
      end
    end

    check("rw_reg3", rw_regs[127:96], 32'h12345678);
    check("rw_reg0", rw_regs[31:0], 32'hAAAA5555);
    check("rw_reg7", rw_regs[255:224], 32'hFFFFFFFF);
    check("rw_reg5", rw_regs[191:160], 32'h0);

    // Exact latency: old result held at S+2, new one at S+3.
    bus_wr(24'h000006, 32'hCAFEBABE, 32'h0);
    addr = 24'h000006; control_rd = 1'b1; control_strobe = 1'b1;
    @(negedge clk);
    control_strobe = 1'b0; control_rd = 1'b0;
    @(negedge clk);
    check("lat_hold", data_in, 32'h00000006);
    @(negedge clk);
    check("lat_new", data_in, 32'hCAFEBABE);

    // Back-to-back reads return in order on consecutive cycles.
    adr4[0] = 24'h000010; adr4[1] = 24'h000011; adr4[2] = 24'h000100; adr4[3] = 24'h000016;
    exp4[0] = 32'h4C425247; exp4[1] = 32'h0; exp4[2] = 32'hDEADF00D; exp4[3] = 32'hDEADF00D;
    for (int i = 0; i < 7; i++) begin
      if (i >= 3) check($sformatf("b2b_%0d", i - 3), data_in, exp4[i-3]);
      if (i < 4) begin
        addr = adr4[i]; control_rd = 1'b1; control_strobe = 1'b1;
        if (i == 1) exp4[1] = tb_cyc;
      end else begin
        control_strobe = 1'b0; control_rd = 1'b0;
      end
      @(negedge clk);
    end

    // Single and back-to-back pulses.
    addr = 24'h000014; data_out = 32'h000000A5; control_rd = 1'b0; control_strobe = 1'b1;
    @(negedge clk);
    control_strobe = 1'b0;
    check("pulse_a5", pulse_out, 32'h000000A5);
    @(negedge clk);
    check("pulse_off", pulse_out, 32'h0);
    bus_rd(24'h000014, 32'h0, q);
    check("pulse_rd0", q, 32'h0);
    addr = 24'h000014; data_out = 32'h1; control_strobe = 1'b1;
    @(negedge clk);
    data_out = 32'h2;
    check("pulse_b2b_1", pulse_out, 32'h1);
    @(negedge clk);
    control_strobe = 1'b0;
    check("pulse_b2b_2", pulse_out, 32'h2);
    @(negedge clk);
    check("pulse_b2b_off", pulse_out, 32'h0);

    // Sticky set, set-wins-over-clear, then clear.
    status_in = 32'h10;
    @(negedge clk);
    status_in = 32'h0;
    check("sticky_set", sticky_out, 32'h10);
    @(negedge clk);
    check("sticky_hold", sticky_out, 32'h10);
    bus_wr(24'h000015, 32'h10, 32'h10);
    check("sticky_setwins", sticky_out, 32'h10);
    bus_wr(24'h000015, 32'h10, 32'h0);
    check("sticky_clr", sticky_out, 32'h0);

    // Read in flight at reset is discarded; strobe during reset ignored.
    addr = 24'h000003; control_rd = 1'b1; control_strobe = 1'b1;
    @(negedge clk);
    rst = 1'b1; addr = 24'h000001; data_out = 32'h55; control_rd = 1'b0;
    @(negedge clk);
    rst = 1'b0; control_strobe = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_flight_%0d", i), data_in, 32'h0);
      @(negedge clk);
    end
    for (int k = 0; k < 8; k++) check($sformatf("rst_rwflat%0d", k), rw_regs[32*k +: 32], 32'h0);
    for (int k = 0; k < 8; k++) begin
      bus_rd(24'(k), 32'h0, q);
      check($sformatf("rst_rd%0d", k), q, 32'h0);
    end
    bus_rd(24'h000012, 32'h0, q);
    check("rst_wrcnt", q, 32'h0);
    bus_rd(24'h000015, 32'h0, q);
    check("rst_sticky_rd", q, 32'h0);

    // Cycle counter wrap.
    force dut.cycle_cnt = 32'hFFFFFFFD;
    release dut.cycle_cnt;
    exp4[0] = 32'hFFFFFFFD; exp4[1] = 32'hFFFFFFFE; exp4[2] = 32'hFFFFFFFF; exp4[3] = 32'h0;
    for (int i = 0; i < 7; i++) begin
      if (i >= 3) check($sformatf("cyc_wrap_%0d", i - 3), data_in, exp4[i-3]);
      if (i < 4) begin
        addr = 24'h000011; control_rd = 1'b1; control_strobe = 1'b1;
      end else begin
        control_strobe = 1'b0; control_rd = 1'b0;
      end
      @(negedge clk);
    end

    // Write count wrap.
    force dut.wr_cnt = 32'hFFFFFFFE;
    release dut.wr_cnt;
    bus_wr(24'h000020, 32'h0, 32'h0);
    bus_rd(24'h000012, 32'h0, q);
    check("wr_wrap_ff", q, 32'hFFFFFFFF);
    bus_wr(24'h000020, 32'h0, 32'h0);
    bus_rd(24'h000012, 32'h0, q);
    check("wr_wrap_0", q, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lb_reg_bank.md
Name: lb_reg_bank

Overview:
- Local-bus register bank on the downstream side of the UDP memory gateway.
- Decodes the gateway's 24-bit local bus and holds eight read/write scratch/config registers.
- Also provides an ID constant, a free-running cycle counter, a write counter, a status snapshot, a pulse register and a sticky status register.
- Returns read data at the fixed latency the gateway expects, so the gateway can splice it into reply packets.

Parameters:
- read_pipe_len, 3: cycles from the read strobe cycle to valid rd_data; legal range 2..8.
- id_value, 32'h4C425247: constant returned at address 0x10.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  24  local bus address; valid in the cycle control_strobe is high.
- control_strobe  input  1  one-cycle bus transaction strobe.
- control_rd  input  1  high together with the strobe means read; low means write.
- data_out  input  32  write data from the gateway; valid with the strobe.
- data_in  output  32  read data to the gateway.
- rw_regs  output  256  flat view of the eight R/W registers; reg k occupies bits [32k+31:32k].
- pulse_out  output  32  one-cycle pulses from writes to 0x14.
- status_in  input  32  asynchronous-origin status bits; already synchronised by the user.
- sticky_out  output  32  current sticky register.

Behaviour:
- Write: control_strobe & ~control_rd. Read: control_strobe & control_rd.
- Hit condition: addr[23:8]==0. Any other address is unmapped.
- Register map for addr[7:0]:
  - 0x00-0x07: R/W regs.
  - 0x10: id_value (RO).
  - 0x11: cycle counter (RO).
  - 0x12: write count (RO).
  - 0x13: status_in snapshot (RO).
  - 0x14: pulse register (reads 0).
  - 0x15: sticky, write-1-to-clear.
  - Everything else, and all unmapped addresses: reads 32'hDEADF00D; writes are ignored.
- R/W regs: updated at the clock edge ending the write-strobe cycle. Visible on rw_regs the next cycle.
- Cycle counter: 32-bit, increments every cycle, wraps 0xFFFFFFFF->0.
- Write count: 32-bit, +1 per write strobe at any address, mapped or not. Wraps.
- Pulse: a write to 0x14 with value V drives pulse_out=V for exactly one cycle, the cycle after the strobe; otherwise 0. Back-to-back writes give consecutive pulse cycles with the respective values.
- Sticky: each cycle sticky <= (sticky & ~clr) | status_in, where clr = data_out on a write to 0x15, else 0. Set wins over a same-cycle clear.
- Read pipeline:
  - The mux value is sampled in the strobe cycle. Counter reads return the value present during the strobe cycle.
  - The value is registered, then delayed so that data_in carries it in cycle S+read_pipe_len (S = strobe cycle).
  - data_in holds that value until the next read result arrives.
  - Fully pipelined: read strobes on consecutive cycles produce results on consecutive cycles, in order.
- A write never disturbs an in-flight read result.
- A read in cycle S+1 of address A written in cycle S returns the new value.
- Reset (rst high at a clock edge) clears:
  - all R/W regs, both counters and sticky;
  - pulse_out to 0, data_in to 0, the read pipeline contents and status snapshots.
  - A read in flight at reset is discarded; data_in stays 0 until a post-reset read completes.
  - A strobe in the same cycle as rst is ignored.
- Reset values of outputs: data_in=0, rw_regs=0, pulse_out=0, sticky_out=0.
- control_rd high without control_strobe has no effect.

Test Plan:
- Write 0x12345678 to 0x03, then read 0x03 -> data_in=0x12345678 exactly read_pipe_len cycles after the read strobe; rw_regs[127:96]=0x12345678; write count=1.
- Read 0x10, 0x11, 0x000100 and 0x16 on four consecutive strobes -> results on consecutive cycles:
  - 0x4C425247;
  - counter value at that strobe;
  - 0xDEADF00D;
  - 0xDEADF00D.
- Write 0x000000A5 to 0x14 -> pulse_out=0xA5 for one cycle only, then 0; read 0x14 returns 0.
- status_in bit4 pulses high for one cycle -> sticky bit4 set and held. Write 0x10 to 0x15 while status_in bit4 is high -> bit remains set. Write again with status_in low -> bit clears.
- Preload the cycle counter to near wrap by running 2^32 cycles, or force it in the bench -> 0xFFFFFFFF then 0x00000000; write count wraps likewise.
- Issue a read, assert rst one cycle later -> data_in=0 afterwards, no stale result; all regs read back 0 after reset.
